// File: rtl/pll_drp_ctrl.sv
// DRP initiator: holds the PLL in reset, applies a stream of read-modify-write
// register updates, then releases reset and waits for lock.
// Optional readback verify of every write is compiled in with PLL_DRP_VERIFY_EN.
`timescale 1ns/1ps

module pll_drp_ctrl #(
  parameter int unsigned RST_HOLD     = 4,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [6:0]  CFG_ADDR,
  input  logic [15:0] CFG_MASK,
  input  logic [15:0] CFG_DATA,
  input  logic        CFG_LAST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  output logic        PLL_RST,
  input  logic        PLL_LOCKED,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ASSERT_RST,
    S_WAIT_ENTRY,
    S_READ,
    S_READ_WAIT,
    S_WRITE,
    S_WRITE_WAIT,
`ifdef PLL_DRP_VERIFY_EN
    S_VERIFY,
    S_VERIFY_WAIT,
`endif
    S_RELEASE,
    S_WAIT_LOCK
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_DRDY   = 2'd1,
    ERR_LOCK   = 2'd2,
    ERR_VERIFY = 2'd3
  } err_code_e;

  // Counters compare against "last cycle" values so a count of N spans N cycles.
  localparam logic [15:0] RST_LAST  = 16'(RST_HOLD - 1);
  localparam logic [15:0] DRDY_LAST = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] data_q, data_d;
  logic        last_q, last_d;
  logic [15:0] di_q, di_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;
  logic        pll_rst_q, pll_rst_d;
  logic        lock_meta_q, lock_s_q;

  logic        cfg_ready, den, dwe;
  logic        fail;
  err_code_e   fail_code;
  logic [15:0] rmw_data;

  assign rmw_data = (DO & mask_q) | (data_q & ~mask_q);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    data_d     = data_q;
    last_d     = last_q;
    di_d       = di_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    pll_rst_d  = pll_rst_q;
    cfg_ready  = 1'b0;
    den        = 1'b0;
    dwe        = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          busy_d     = 1'b1;
          pll_rst_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_ASSERT_RST;
        end
      end

      S_ASSERT_RST: begin
        if (cnt_q >= RST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_ENTRY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WAIT_ENTRY: begin
        cfg_ready = 1'b1;
        if (CFG_VALID) begin
          addr_d  = CFG_ADDR;
          mask_d  = CFG_MASK;
          data_d  = CFG_DATA;
          last_d  = CFG_LAST;
          state_d = S_READ;
        end
      end

      // DRDY is only honoured from the cycle after DEN; the count starts at 1
      // so the timeout is measured from the DEN cycle itself.
      S_READ: begin
        den     = 1'b1;
        cnt_d   = 16'd1;
        state_d = S_READ_WAIT;
      end

      S_READ_WAIT: begin
        if (DRDY) begin
          di_d    = rmw_data;
          state_d = S_WRITE;
        end else if (cnt_q >= DRDY_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_DRDY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WRITE: begin
        den     = 1'b1;
        dwe     = 1'b1;
        cnt_d   = 16'd1;
        state_d = S_WRITE_WAIT;
      end

      S_WRITE_WAIT: begin
        if (DRDY) begin
`ifdef PLL_DRP_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = last_q ? S_RELEASE : S_WAIT_ENTRY;
`endif
        end else if (cnt_q >= DRDY_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_DRDY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

`ifdef PLL_DRP_VERIFY_EN
      S_VERIFY: begin
        den     = 1'b1;
        cnt_d   = 16'd1;
        state_d = S_VERIFY_WAIT;
      end

      S_VERIFY_WAIT: begin
        if (DRDY) begin
          if (DO != di_q) begin
            fail      = 1'b1;
            fail_code = ERR_VERIFY;
          end else begin
            state_d = last_q ? S_RELEASE : S_WAIT_ENTRY;
          end
        end else if (cnt_q >= DRDY_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_DRDY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif

      S_RELEASE: begin
        pll_rst_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_WAIT_LOCK;
      end

      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q >= LOCK_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_LOCK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Every error path ends the sequence identically; ERR stays until START.
    if (fail) begin
      err_d      = 1'b1;
      err_code_d = fail_code;
      pll_rst_d  = 1'b0;
      busy_d     = 1'b0;
      cnt_d      = '0;
      state_d    = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      di_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      pll_rst_q   <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      last_q      <= last_d;
      di_q        <= di_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pll_rst_q   <= pll_rst_d;
      lock_meta_q <= PLL_LOCKED;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign CFG_READY = cfg_ready;
  assign DEN       = den;
  assign DWE       = dwe;
  assign DADDR     = addr_q;
  assign DI        = di_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ERR_CODE  = err_code_q;
  assign PLL_RST   = pll_rst_q;

endmodule
